jam_ctrl: RTL and testbench

Sequencing controller for the job-assignment (JAM) permutation datapath. It fetches the 8x8 worker/job cost table from an external cost memory and writes it into the engine's table. It then drives the engine through every permutation with init/step strobes, tracks the minimum total cost and how many permutations reach it, and presents the result under a Valid/ack handshake. A watchdog flags an engine that never reports its final permutation.

---
 rtl/jam_ctrl.sv | 134 +++++++++++++
 tb/tb_jam_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jam_ctrl.sv
// Sequencer for the JAM permutation engine: loads the 8x8 cost table, steps the
// engine through all permutations, tracks min cost / match count, and guards with a watchdog.
module jam_ctrl #(
  parameter int NPERM  = 40320,
  parameter int COST_W = 7,
  parameter int TOT_W  = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic [2:0]        W,
  output logic [2:0]        J,
  input  logic [COST_W-1:0] Cost,
  output logic              tbl_we,
  output logic [2:0]        tbl_w,
  output logic [2:0]        tbl_j,
  output logic [COST_W-1:0] tbl_data,
  output logic              perm_init,
  output logic              perm_step,
  input  logic              total_vld,
  input  logic [TOT_W-1:0]  total_in,
  input  logic              perm_last,
  output logic [TOT_W-1:0]  MinCost,
  output logic [3:0]        MatchCount,
  output logic              Valid,
  input  logic              res_ack,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: Valid is high for every DONE cycle; the result is consumed on the
  // edge where Valid and res_ack are both high, and Valid drops the following cycle.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INIT = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [15:0] LAST_EVAL = 16'(NPERM - 1);
  localparam logic [6:0]  LOAD_END  = 7'd64;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  ld_cnt;
  logic [5:0]  addr_q;
  logic [15:0] eval_cnt;
  logic        last_eval;

  assign last_eval = (eval_cnt == LAST_EVAL);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: if (ld_cnt == LOAD_END) state_nxt = S_INIT;
      S_INIT: state_nxt = S_RUN;
      S_RUN:  if (total_vld && (perm_last || last_eval)) state_nxt = S_DONE;
      S_DONE: if (res_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Cost data returns one cycle after its address, so the table write uses the
  // address registered on the previous LOAD cycle.
  always_comb begin
    busy      = (state != S_IDLE);
    W         = 3'd0;
    J         = 3'd0;
    tbl_we    = 1'b0;
    tbl_w     = 3'd0;
    tbl_j     = 3'd0;
    tbl_data  = '0;
    perm_init = (state == S_INIT);
    perm_step = 1'b0;
    Valid     = (state == S_DONE);
    if (state == S_LOAD) begin
      W = ld_cnt[5:3];
      J = ld_cnt[2:0];
      if (ld_cnt != 7'd0) begin
        tbl_we   = 1'b1;
        tbl_w    = addr_q[5:3];
        tbl_j    = addr_q[2:0];
        tbl_data = Cost;
      end
    end
    if (state == S_RUN && total_vld && !perm_last && !last_eval)
      perm_step = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ld_cnt     <= 7'd0;
      addr_q     <= 6'd0;
      eval_cnt   <= 16'd0;
      MinCost    <= '1;
      MatchCount <= 4'd0;
      err        <= 1'b0;
    end else begin
      ld_cnt <= (state == S_LOAD) ? ld_cnt + 7'd1 : 7'd0;
      addr_q <= ld_cnt[5:0];
      case (state)
        S_IDLE: if (start) err <= 1'b0;
        S_INIT: begin
          MinCost    <= '1;
          MatchCount <= 4'd0;
          eval_cnt   <= 16'd0;
        end
        S_RUN: if (total_vld) begin
          eval_cnt <= eval_cnt + 16'd1;
          if (total_in < MinCost) begin
            MinCost    <= total_in;
            MatchCount <= 4'd1;
          end else if (total_in == MinCost && MatchCount != 4'hF) begin
            MatchCount <= MatchCount + 4'd1;
          end
          // A final permutation landing exactly on the budget is a normal finish.
          if (!perm_last && last_eval) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_ctrl.sv
// Directed bench for jam_ctrl: table load order, min/count tracking, saturation,
// watchdog, result handshake and mid-run reset.
module tb_jam_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        busy;
  logic [2:0]  W, J;
  logic [6:0]  Cost;
  logic        tbl_we;
  logic [2:0]  tbl_w, tbl_j;
  logic [6:0]  tbl_data;
  logic        perm_init, perm_step;
  logic        total_vld;
  logic [9:0]  total_in;
  logic        perm_last;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        Valid;
  logic        res_ack;
  logic        err;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  tab [5];
  int          steps;

  jam_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .W(W), .J(J), .Cost(Cost),
    .tbl_we(tbl_we), .tbl_w(tbl_w), .tbl_j(tbl_j), .tbl_data(tbl_data),
    .perm_init(perm_init), .perm_step(perm_step), .total_vld(total_vld),
    .total_in(total_in), .perm_last(perm_last), .MinCost(MinCost),
    .MatchCount(MatchCount), .Valid(Valid), .res_ack(res_ack), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // cost memory model: one-cycle read latency, Cost = 8*W + J
  always @(posedge CLK) Cost <= {1'b0, W, J};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_valid"}, 32'(Valid),      32'd0);
    check({tag, "_min"},   32'(MinCost),    32'd1023);
    check({tag, "_cnt"},   32'(MatchCount), 32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_we"},    32'(tbl_we),     32'd0);
    check({tag, "_wj"},    32'({W, J, tbl_w, tbl_j, tbl_data}), 32'd0);
    check({tag, "_init"},  32'(perm_init),  32'd0);
    check({tag, "_step"},  32'(perm_step),  32'd0);
  endtask

  // Pulse start, then watch 66 cycles: table writes in address order, perm_init on cycle 66.
  task automatic start_and_load(input string tag);
    int idx = 0;
    int init_cyc = -1;
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 66; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) check({tag, "_err_clr"}, 32'(err), 32'd0);
      if (tbl_we) begin
        check({tag, "_ld_addr"}, 32'({tbl_w, tbl_j}), 32'(idx));
        check({tag, "_ld_data"}, 32'(tbl_data), 32'(idx));
        idx++;
      end
      if (perm_init && init_cyc < 0) init_cyc = cyc;
    end
    check({tag, "_ld_count"}, 32'(idx), 32'd64);
    check({tag, "_init_cyc"}, 32'(init_cyc), 32'd66);
  endtask

  // Engine model: n evaluations, optional random stalls, perm_last on the final one if has_last.
  task automatic run_engine(input int n, input bit fixed, input logic [9:0] fval,
                            input bit has_last, input int max_stall, output int nstep);
    nstep = 0;
    @(posedge CLK); #1;
    for (int i = 0; i < n; i++) begin
      int ns = int'($urandom_range(max_stall, 0));
      for (int s = 0; s < ns; s++) begin
        total_vld = 1'b0;
        @(negedge CLK); if (perm_step) nstep++;
        @(posedge CLK); #1;
      end
      total_vld = 1'b1;
      total_in  = fixed ? fval : tab[i];
      perm_last = has_last && (i == n - 1);
      @(negedge CLK); if (perm_step) nstep++;
      @(posedge CLK); #1;
    end
    total_vld = 1'b0;
    perm_last = 1'b0;
  endtask

  task automatic ack_result();
    @(posedge CLK); #1 res_ack = 1'b1;
    @(posedge CLK); #1 res_ack = 1'b0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; total_vld = 1'b0; total_in = '0;
    perm_last = 1'b0; res_ack = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset("por");
    @(posedge CLK); #1 RST = 1'b0;

    // min / count with stalls, then handshake
    tab = '{10'd100, 10'd50, 10'd50, 10'd70, 10'd50};
    start_and_load("t1");
    run_engine(5, 1'b0, 10'd0, 1'b1, 3, steps);
    @(negedge CLK);
    check("t1_valid", 32'(Valid), 32'd1);
    check("t1_min",   32'(MinCost), 32'd50);
    check("t1_cnt",   32'(MatchCount), 32'd3);
    check("t1_err",   32'(err), 32'd0);
    check("t1_steps", 32'(steps), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1 start = (i == 4);
      @(negedge CLK);
      check("hs_valid", 32'(Valid), 32'd1);
      check("hs_hold",  32'({MinCost, MatchCount, err}), 32'({10'd50, 4'd3, 1'b0}));
    end
    @(posedge CLK); #1 start = 1'b0;
    ack_result();
    @(negedge CLK);
    check("hs_ack_valid", 32'(Valid), 32'd0);
    check("hs_ack_busy",  32'(busy), 32'd0);
    check("hs_retain",    32'({MinCost, MatchCount}), 32'({10'd50, 4'd3}));
    @(negedge CLK);
    check("hs_start_ign", 32'(busy), 32'd0);

    // saturation, perm_last coinciding with the watchdog limit; ack held high
    res_ack = 1'b1;
    start_and_load("t2");
    run_engine(40320, 1'b1, 10'd8, 1'b1, 0, steps);
    @(negedge CLK);
    check("t2_valid", 32'(Valid), 32'd1);
    check("t2_min",   32'(MinCost), 32'd8);
    check("t2_cnt",   32'(MatchCount), 32'd15);
    check("t2_err",   32'(err), 32'd0);
    check("t2_steps", 32'(steps), 32'd40319);
    @(negedge CLK);
    check("t2_valid_1cyc", 32'(Valid), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);
    @(posedge CLK); #1 res_ack = 1'b0;

    // watchdog: perm_last never arrives
    start_and_load("t3");
    run_engine(40320, 1'b1, 10'd500, 1'b0, 0, steps);
    @(negedge CLK);
    check("t3_valid", 32'(Valid), 32'd1);
    check("t3_err",   32'(err), 32'd1);
    check("t3_min",   32'(MinCost), 32'd500);
    check("t3_cnt",   32'(MatchCount), 32'd15);
    check("t3_steps", 32'(steps), 32'd40319);
    ack_result();
    @(negedge CLK);
    check("t3_err_retain", 32'(err), 32'd1);
    check("t3_ack_valid",  32'(Valid), 32'd0);

    // reset in the middle of RUN, then a complete solve
    start_and_load("t4");
    run_engine(1000, 1'b1, 10'd200, 1'b0, 0, steps);
    check("t4_run_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_reset("mid");
    @(posedge CLK); #1 RST = 1'b0;
    tab = '{10'd300, 10'd20, 10'd90, 10'd20, 10'd1016};
    start_and_load("t5");
    run_engine(5, 1'b0, 10'd0, 1'b1, 2, steps);
    @(negedge CLK);
    check("t5_valid", 32'(Valid), 32'd1);
    check("t5_min",   32'(MinCost), 32'd20);
    check("t5_cnt",   32'(MatchCount), 32'd2);
    check("t5_err",   32'(err), 32'd0);
    check("t5_steps", 32'(steps), 32'd4);
    ack_result();
    @(negedge CLK);
    check("t5_idle", 32'({busy, Valid}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
